// File: rtl/demux4b4_buf.sv
// Registered 1-to-4 nibble demultiplexer with four single-entry valid/ready lane buffers.
// Optional broadcast to all lanes is enabled with the DEMUX4B4_BCAST_EN macro (adds input BC).
module demux4b4_buf (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] I,
  input  logic [1:0] S,
  input  logic       IV,
  output logic       IR,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic       AV,
  output logic       BV,
  output logic       CV,
  output logic       DV,
  input  logic       AR,
  input  logic       BR,
  input  logic       CR,
  input  logic       DR
`ifdef DEMUX4B4_BCAST_EN
  ,
  input  logic       BC
`endif
);

  localparam int unsigned NumLanes = 4;

  logic [3:0] data_q [NumLanes];
  logic [3:0] data_d [NumLanes];
  logic [NumLanes-1:0] vld_q, vld_d;

  logic [NumLanes-1:0] rdy;
  logic [NumLanes-1:0] drain;
  logic [NumLanes-1:0] free;
  logic [NumLanes-1:0] sel;
  logic [NumLanes-1:0] load;
  logic                bcast;

`ifdef DEMUX4B4_BCAST_EN
  assign bcast = BC;
`else
  assign bcast = 1'b0;
`endif

  assign rdy   = {DR, CR, BR, AR};
  assign drain = vld_q & rdy;
  // A lane that drains this cycle can take new data on the same edge.
  assign free  = ~vld_q | drain;

  always_comb begin
    sel = '0;
    IR  = 1'b0;
    if (bcast) begin
      sel = '1;
      IR  = &free;
    end else begin
      sel[S] = 1'b1;
      IR     = free[S];
    end
  end

  assign load = (IV && IR) ? sel : '0;

  always_comb begin
    vld_d = (vld_q & ~drain) | load;
    for (int i = 0; i < NumLanes; i++) begin
      data_d[i] = load[i] ? I : data_q[i];
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      vld_q <= '0;
      for (int i = 0; i < NumLanes; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < NumLanes; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign A  = data_q[0];
  assign B  = data_q[1];
  assign C  = data_q[2];
  assign D  = data_q[3];
  assign AV = vld_q[0];
  assign BV = vld_q[1];
  assign CV = vld_q[2];
  assign DV = vld_q[3];

endmodule

// File: tb/tb_demux4b4_buf.sv
// Self-checking bench for demux4b4_buf: directed steps from the test plan plus random traffic
// compared against a lane-buffer reference model.
module tb_demux4b4_buf;

  logic       clk;
  logic       rst;
  logic [3:0] in_d;
  logic [1:0] in_s;
  logic       in_v;
  logic       in_r;
  logic [3:0] a, b, c, d;
  logic       av, bv, cv, dv;
  logic [3:0] rdy;
  logic       bc;

  demux4b4_buf dut (
    .CLK  (clk),
    .Reset(rst),
    .I    (in_d),
    .S    (in_s),
    .IV   (in_v),
    .IR   (in_r),
    .A    (a),
    .B    (b),
    .C    (c),
    .D    (d),
    .AV   (av),
    .BV   (bv),
    .CV   (cv),
    .DV   (dv),
    .AR   (rdy[0]),
    .BR   (rdy[1]),
    .CR   (rdy[2]),
    .DR   (rdy[3])
`ifdef DEMUX4B4_BCAST_EN
    ,
    .BC   (bc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: four buffers, each either empty or holding one nibble.
  logic [3:0] m_data [4];
  bit         m_full [4];

  logic [3:0] obs_d [4];
  logic       obs_v [4];
  assign obs_d[0] = a;
  assign obs_d[1] = b;
  assign obs_d[2] = c;
  assign obs_d[3] = d;
  assign obs_v[0] = av;
  assign obs_v[1] = bv;
  assign obs_v[2] = cv;
  assign obs_v[3] = dv;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit lane_can_take(int k);
    return !m_full[k] || rdy[k];
  endfunction

  function automatic bit model_ir();
    bit all_free = 1'b1;
    for (int k = 0; k < 4; k++) all_free &= lane_can_take(k);
    if (bc) return all_free;
    return lane_can_take(int'(in_s));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_data[k] = 4'h0;
      m_full[k] = 1'b0;
    end
  endtask

  task automatic check_lanes(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s data[%0d]", tag, k), obs_d[k], m_data[k]);
      chk($sformatf("%s valid[%0d]", tag, k), {3'b0, obs_v[k]}, {3'b0, m_full[k]});
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step(input string tag);
    bit take;
    #1;
    chk({tag, " IR"}, {3'b0, in_r}, {3'b0, model_ir()});
    take = in_v && model_ir();
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (take && (bc || int'(in_s) == k)) begin
        m_data[k] = in_d;
        m_full[k] = 1'b1;
      end else if (m_full[k] && rdy[k]) begin
        m_full[k] = 1'b0;
      end
    end
    #1;
    check_lanes(tag);
  endtask

  task automatic drive(input logic [3:0] di, input logic [1:0] si, input logic vi,
                       input logic [3:0] ri);
    in_d = di;
    in_s = si;
    in_v = vi;
    rdy  = ri;
  endtask

  initial begin
    rst = 1'b1;
    bc  = 1'b0;
    drive(4'h0, 2'd0, 1'b0, 4'h0);
    model_reset();
    #2;
    check_lanes("in_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_reset IR", {3'b0, in_r}, 4'h1);
    @(posedge clk);
    #1;

    // Steering into all four lanes with no consumer ready
    drive(4'hA, 2'd0, 1'b1, 4'h0); step("steer_a");
    drive(4'hB, 2'd1, 1'b1, 4'h0); step("steer_b");
    drive(4'hC, 2'd2, 1'b1, 4'h0); step("steer_c");
    drive(4'h0, 2'd3, 1'b1, 4'h0); step("steer_d");
    chk("steer A", a, 4'hA);
    chk("steer B", b, 4'hB);
    chk("steer C", c, 4'hC);
    chk("steer D", d, 4'h0);
    chk("steer all valid", {av, bv, cv, dv}, 4'hF);

    // Backpressure on lane A, then release
    drive(4'h5, 2'd0, 1'b1, 4'h0);
    for (int n = 0; n < 3; n++) step("bp_hold");
    chk("bp IR low", {3'b0, in_r}, 4'h0);
    chk("bp A held", a, 4'hA);
    rdy = 4'b0001;
    #1;
    chk("bp IR same cycle", {3'b0, in_r}, 4'h1);
    step("bp_release");
    chk("bp A loaded", a, 4'h5);
    chk("bp AV", {3'b0, av}, 4'h1);

    // Drain lane B without refill
    drive(4'h0, 2'd1, 1'b0, 4'b0010); step("drain_b");
    chk("drain BV", {3'b0, bv}, 4'h0);
    chk("drain B held", b, 4'hB);

    // Full throughput on lane C
    drive(4'h1, 2'd2, 1'b1, 4'b0100); step("tput1");
    chk("tput C1", c, 4'h1);
    drive(4'h2, 2'd2, 1'b1, 4'b0100); step("tput2");
    chk("tput C2", c, 4'h2);
    drive(4'h3, 2'd2, 1'b1, 4'b0100); step("tput3");
    chk("tput C3", c, 4'h3);
    chk("tput CV", {3'b0, cv}, 4'h1);

    // Asynchronous reset mid-cycle with A=hA valid
    drive(4'hA, 2'd0, 1'b1, 4'b0001); step("pre_rst");
    drive(4'h0, 2'd0, 1'b0, 4'h0);
    chk("pre_rst A", a, 4'hA);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst A", a, 4'h0);
    chk("async rst AV", {3'b0, av}, 4'h0);
    model_reset();
    rst = 1'b0;
    #1;
    chk("rst release IR", {3'b0, in_r}, 4'h1);
    @(posedge clk);
    #1;

`ifdef DEMUX4B4_BCAST_EN
    bc = 1'b1;
    drive(4'h7, 2'd1, 1'b1, 4'h0); step("bcast_load");
    chk("bcast lanes", {a, b, c, d}, 4'h7);
    chk("bcast valids", {av, bv, cv, dv}, 4'hF);
    drive(4'h9, 2'd0, 1'b1, 4'b0111);
    #1;
    chk("bcast blocked IR", {3'b0, in_r}, 4'h0);
    step("bcast_blocked");
    chk("bcast D kept", d, 4'h7);
    chk("bcast A kept", a, 4'h7);
    bc = 1'b0;
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0), 4'($urandom));
`ifdef DEMUX4B4_BCAST_EN
      bc = ($urandom_range(0, 7) == 0);
`endif
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
